id_ix_pipe_stage: RTL and testbench

ID_IX_PIPE_STAGE -- requirements
Module: id_ix_pipe_stage

---
 rtl/id_ix_pipe_stage_if.sv | 33 +++
 rtl/id_ix_pipe_stage.sv | 152 +++++++++++++++
 tb/tb_id_ix_pipe_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ix_pipe_stage_if.sv
// ID->IX pipeline stage bus: upstream entry, flush and downstream entry.
// Port summary: flush, in_valid/in_ready + pc_in/ir_in/a_in/b_in (ID side),
//               out_valid/out_ready + pc_out/ir_out/a_out/b_out (IX side).
// slave = the stage itself, master = whatever surrounds it (ID/IX/bench).
interface id_ix_pipe_stage_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int IR_W   = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   pc_in;
    logic [IR_W-1:0]   ir_in;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   pc_out;
    logic [IR_W-1:0]   ir_out;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;

    modport slave (
        input  flush, in_valid, pc_in, ir_in, a_in, b_in, out_ready,
        output in_ready, out_valid, pc_out, ir_out, a_out, b_out
    );

    modport master (
        output flush, in_valid, pc_in, ir_in, a_in, b_in, out_ready,
        input  in_ready, out_valid, pc_out, ir_out, a_out, b_out
    );
endinterface

// File: rtl/id_ix_pipe_stage.sv
// Purpose: ID->IX pipeline register stage (PC, IR, A, B) updating on the falling clk edge.
// Latency: one falling edge from acceptance to presentation on the IX side.
// Backpressure: base build in_ready = !out_valid | out_ready (combinational);
//   with ID_IX_SKID_EN a skid register absorbs one entry and in_ready is a flop (= !skid valid).
// Ports: clk, rst (async active-high), bus (id_ix_pipe_stage_if.slave).
// ir_out shows NOP_IR whenever no valid entry is presented.
module id_ix_pipe_stage #(
    parameter int              DATA_W = 32,
    parameter int              PC_W   = 32,
    parameter int              IR_W   = 32,
    parameter logic [IR_W-1:0] NOP_IR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    id_ix_pipe_stage_if.slave     bus
);

    // Main register: the entry presented to IX.
    logic              main_vld_q, main_vld_d;
    logic [PC_W-1:0]   main_pc_q,  main_pc_d;
    logic [IR_W-1:0]   main_ir_q,  main_ir_d;
    logic [DATA_W-1:0] main_a_q,   main_a_d;
    logic [DATA_W-1:0] main_b_q,   main_b_d;

    logic in_rdy;
    logic in_xfer;
    logic out_xfer;

`ifdef ID_IX_SKID_EN
    // Skid register: catches an entry accepted while main is stalled.
    logic              skid_vld_q, skid_vld_d;
    logic [PC_W-1:0]   skid_pc_q,  skid_pc_d;
    logic [IR_W-1:0]   skid_ir_q,  skid_ir_d;
    logic [DATA_W-1:0] skid_a_q,   skid_a_d;
    logic [DATA_W-1:0] skid_b_q,   skid_b_d;
    logic              in_rdy_q,   in_rdy_d;

    assign in_rdy = in_rdy_q;
`else
    assign in_rdy = !main_vld_q || bus.out_ready;
`endif

    assign in_xfer  = bus.in_valid && in_rdy;
    assign out_xfer = main_vld_q && bus.out_ready;

    always_comb begin
        main_vld_d = main_vld_q;
        main_pc_d  = main_pc_q;
        main_ir_d  = main_ir_q;
        main_a_d   = main_a_q;
        main_b_d   = main_b_q;
`ifdef ID_IX_SKID_EN
        skid_vld_d = skid_vld_q;
        skid_pc_d  = skid_pc_q;
        skid_ir_d  = skid_ir_q;
        skid_a_d   = skid_a_q;
        skid_b_d   = skid_b_q;
`endif

        if (bus.flush) begin
            // Drop everything; payload registers keep their contents.
            main_vld_d = 1'b0;
`ifdef ID_IX_SKID_EN
            skid_vld_d = 1'b0;
`endif
        end else begin
`ifdef ID_IX_SKID_EN
            // in_rdy_q is low whenever skid is full, so an input transfer
            // below always lands in an empty register.
            if (!main_vld_q || out_xfer) begin
                if (skid_vld_q) begin
                    main_vld_d = 1'b1;
                    main_pc_d  = skid_pc_q;
                    main_ir_d  = skid_ir_q;
                    main_a_d   = skid_a_q;
                    main_b_d   = skid_b_q;
                    skid_vld_d = 1'b0;
                end else if (in_xfer) begin
                    main_vld_d = 1'b1;
                    main_pc_d  = bus.pc_in;
                    main_ir_d  = bus.ir_in;
                    main_a_d   = bus.a_in;
                    main_b_d   = bus.b_in;
                end else begin
                    main_vld_d = 1'b0;
                end
            end else if (in_xfer) begin
                skid_vld_d = 1'b1;
                skid_pc_d  = bus.pc_in;
                skid_ir_d  = bus.ir_in;
                skid_a_d   = bus.a_in;
                skid_b_d   = bus.b_in;
            end
`else
            if (in_xfer) begin
                // Covers the refill-while-draining case too (one per edge).
                main_vld_d = 1'b1;
                main_pc_d  = bus.pc_in;
                main_ir_d  = bus.ir_in;
                main_a_d   = bus.a_in;
                main_b_d   = bus.b_in;
            end else if (out_xfer) begin
                main_vld_d = 1'b0;
            end
`endif
        end

`ifdef ID_IX_SKID_EN
        in_rdy_d = !skid_vld_d;
`endif
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            main_vld_q <= 1'b0;
            main_pc_q  <= '0;
            main_ir_q  <= '0;
            main_a_q   <= '0;
            main_b_q   <= '0;
`ifdef ID_IX_SKID_EN
            skid_vld_q <= 1'b0;
            skid_pc_q  <= '0;
            skid_ir_q  <= '0;
            skid_a_q   <= '0;
            skid_b_q   <= '0;
            in_rdy_q   <= 1'b1;
`endif
        end else begin
            main_vld_q <= main_vld_d;
            main_pc_q  <= main_pc_d;
            main_ir_q  <= main_ir_d;
            main_a_q   <= main_a_d;
            main_b_q   <= main_b_d;
`ifdef ID_IX_SKID_EN
            skid_vld_q <= skid_vld_d;
            skid_pc_q  <= skid_pc_d;
            skid_ir_q  <= skid_ir_d;
            skid_a_q   <= skid_a_d;
            skid_b_q   <= skid_b_d;
            in_rdy_q   <= in_rdy_d;
`endif
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = main_vld_q;
    assign bus.pc_out    = main_pc_q;
    assign bus.ir_out    = main_vld_q ? main_ir_q : NOP_IR;
    assign bus.a_out     = main_a_q;
    assign bus.b_out     = main_b_q;

endmodule

// File: tb/tb_id_ix_pipe_stage.sv
// Purpose: scoreboard bench for id_ix_pipe_stage (base or ID_IX_SKID_EN build).
// Latency: expects each accepted entry on the IX side one falling edge later.
// Backpressure: directed out_ready patterns with hand-computed in_ready per cycle.
module tb_id_ix_pipe_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef ID_IX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    ent_t exp_q[$];

    always #5 clk = ~clk;

    id_ix_pipe_stage_if #(.DATA_W(32), .PC_W(32), .IR_W(32)) bus();
    id_ix_pipe_stage #(.DATA_W(32), .PC_W(32), .IR_W(32), .NOP_IR(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    id_ix_pipe_stage_if #(.DATA_W(64), .PC_W(48), .IR_W(32)) wbus();
    id_ix_pipe_stage #(.DATA_W(64), .PC_W(48), .IR_W(32), .NOP_IR(NOP)) wdut (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
    );

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc = pc;
        e.ir = 32'h00B0_0033 + pc;
        e.a  = ~pc;
        e.b  = pc << 4;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One cycle of stimulus: inputs change 1 time unit after posedge, the
    // stage commits on the following negedge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic ordy,
                       input logic fl, input logic exp_rdy);
        ent_t e;
        e = mk(pc);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.pc_in     = e.pc;
        bus.ir_in     = e.ir;
        bus.a_in      = e.a;
        bus.b_in      = e.b;
        bus.out_ready = ordy;
        bus.flush     = fl;
        if (fl) exp_q.delete();
        #2;
        chk("in_ready", bus.in_ready, exp_rdy);
        if (v && exp_rdy && !fl) exp_q.push_back(e);
    endtask

    // Monitor: pops and compares whenever an output transfer is about to happen.
    initial begin
        ent_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst === 1'b0 && bus.out_valid && bus.out_ready && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_out: got pc %0h expected no entry", bus.pc_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", bus.pc_out, e.pc);
                    chk("out_ir", bus.ir_out, e.ir);
                    chk("out_a",  bus.a_out,  e.a);
                    chk("out_b",  bus.b_out,  e.b);
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.pc_in     = '0;
        bus.ir_in     = '0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b0;
        wbus.flush     = 1'b0;
        wbus.in_valid  = 1'b0;
        wbus.pc_in     = '0;
        wbus.ir_in     = '0;
        wbus.a_in      = '0;
        wbus.b_in      = '0;
        wbus.out_ready = 1'b0;

        // Reset then idle.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_ir_out",    bus.ir_out,    NOP);
        chk("rst_pc_out",    bus.pc_out,    32'h0);
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Streaming, one per edge.
        cyc(1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'h104, 1'b1, 1'b0, 1'b1);
        chk("lat_valid", bus.out_valid, 1'b1);
        chk("lat_pc",    bus.pc_out,    32'h100);
        cyc(1'b1, 32'h108, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'h0,   1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'h0,   1'b1, 1'b0, 1'b1);
        chk("stream_drained", bus.out_valid, 1'b0);

        // Backpressure.
        cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        if (!SKID) begin
            cyc(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
            cyc(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
            chk("bp_hold_pc", bus.pc_out, 32'h200);
            cyc(1'b1, 32'h204, 1'b1, 1'b0, 1'b1);
            cyc(1'b0, 32'h0,   1'b1, 1'b0, 1'b1);
            cyc(1'b0, 32'h0,   1'b1, 1'b0, 1'b1);
        end else begin
            cyc(1'b1, 32'h204, 1'b0, 1'b0, 1'b1);
            cyc(1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
            chk("bp_hold_pc", bus.pc_out, 32'h200);
            cyc(1'b0, 32'h0,   1'b1, 1'b0, 1'b0);
            cyc(1'b0, 32'h0,   1'b1, 1'b0, 1'b1);
            cyc(1'b0, 32'h0,   1'b1, 1'b0, 1'b1);
        end
        chk("bp_drained", bus.out_valid, 1'b0);

        // Flush colliding with an input and an output transfer.
        cyc(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h304, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 32'h0,   1'b1, 1'b0, 1'b1);
        chk("flush_valid", bus.out_valid, 1'b0);
        chk("flush_ir",    bus.ir_out,    NOP);
        chk("flush_pc",    bus.pc_out,    32'h300);
        cyc(1'b0, 32'h0,   1'b1, 1'b0, 1'b1);

        // Async reset while the stage is stalled and full.
        cyc(1'b1, 32'h400, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h404, 1'b0, 1'b0, SKID);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_valid", bus.out_valid, 1'b0);
        chk("arst_ir",    bus.ir_out,    NOP);
        chk("arst_pc",    bus.pc_out,    32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        chk("arst_in_ready", bus.in_ready,  1'b1);
        chk("arst_valid2",   bus.out_valid, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Wide instance: 64-bit operands, 48-bit PC.
        @(posedge clk);
        #1;
        wbus.in_valid  = 1'b1;
        wbus.pc_in     = 48'hABCD_1234_5678;
        wbus.ir_in     = 32'h0000_0001;
        wbus.a_in      = 64'hDEAD_BEEF_CAFE_F00D;
        wbus.b_in      = 64'h0123_4567_89AB_CDEF;
        wbus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        wbus.in_valid = 1'b0;
        #1;
        chk("wide_valid", wbus.out_valid, 1'b1);
        chk("wide_a",     wbus.a_out,     64'hDEAD_BEEF_CAFE_F00D);
        chk("wide_b",     wbus.b_out,     64'h0123_4567_89AB_CDEF);
        chk("wide_pc",    {16'h0, wbus.pc_out}, 64'h0000_ABCD_1234_5678);
        chk("wide_ir",    wbus.ir_out,    32'h0000_0001);

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
